// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Multi-cycle MIPS-style main controller. A Moore FSM walks each instruction
// through FETCH/DECODE and one or more execute states. Every datapath control
// signal is decoded from the current state. The only exception is ALUOp in
// MEM_ADDR, which also looks at the opcode latched in DECODE.
//
// Ports
//   clk           in   single clock, rising-edge state updates
//   rst_n         in   asynchronous active-low reset
//   Opcode[5:0]   in   IR[31:26], stable from DECODE until the next FETCH
//   ALUOp[3:0]    out  operation class for ALU_control
//   PCWrite       out  unconditional PC write
//   PCWriteCond   out  PC write gated by Zero (beq)
//   PCWriteCondNe out  PC write gated by !Zero (bne)
//   IorD          out  memory address select (1 = ALUOut)
//   MemRead       out  memory read strobe
//   MemWrite      out  memory write strobe
//   IRWrite       out  instruction register load
//   MemtoReg      out  writeback select (1 = MDR)
//   RegDst        out  destination register select (1 = rd)
//   RegWrite      out  register file write enable
//   ALUSrcA       out  ALU A select (1 = reg A)
//   ALUSrcB[1:0]  out  ALU B select (00 B, 01 +4, 10 imm, 11 imm<<2)
//   PCSource[1:0] out  PC source (00 ALU, 01 ALUOut, 10 jump target)
//   state[3:0]    out  current state code (debug)
//   instr_done    out  high while in a terminal (retiring) state
//   instr_cnt     out  retired instruction count, wraps at 16 bits
//   err_flag      out  sticky illegal-opcode flag
// ---------------------------------------------------------------------------
module control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  Opcode,
    output logic [3:0]  ALUOp,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        PCWriteCondNe,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic [15:0] instr_cnt,
    output logic        err_flag
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXE    = 4'd6,
        S_R_WB     = 4'd7,
        S_BEQ      = 4'd8,
        S_BNE      = 4'd9,
        S_JUMP     = 4'd10,
        S_SET_EXE  = 4'd11,
        S_SET_WB   = 4'd12,
        S_UNUSED13 = 4'd13,
        S_UNUSED14 = 4'd14,
        S_INIT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_SET = 6'b001010;

    localparam logic [3:0] ALU_LW  = 4'b0000;
    localparam logic [3:0] ALU_SW  = 4'b0001;
    localparam logic [3:0] ALU_BEQ = 4'b0010;
    localparam logic [3:0] ALU_BNE = 4'b0011;
    localparam logic [3:0] ALU_R   = 4'b0100;
    localparam logic [3:0] ALU_SET = 4'b0101;
    localparam logic [3:0] ALU_JMP = 4'b0110;

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_op_q;
    logic [15:0] r_instr_cnt;
    logic        r_err_flag;
    logic        w_illegal;
    logic        w_done;

    // Next-state logic. w_illegal is only raised while decoding.
    always_comb begin
        w_state_next = S_FETCH;
        w_illegal    = 1'b0;
        case (r_state)
            S_INIT:     w_state_next = S_FETCH;
            S_FETCH:    w_state_next = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_R:         w_state_next = S_R_EXE;
                    OP_LW, OP_SW: w_state_next = S_MEM_ADDR;
                    OP_BEQ:       w_state_next = S_BEQ;
                    OP_BNE:       w_state_next = S_BNE;
                    OP_J:         w_state_next = S_JUMP;
                    OP_SET:       w_state_next = S_SET_EXE;
                    default: begin
                        w_state_next = S_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            // Only lw and sw reach MEM_ADDR, so a single compare is enough.
            S_MEM_ADDR: w_state_next = (r_op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_state_next = S_MEM_WB;
            S_R_EXE:    w_state_next = S_R_WB;
            S_SET_EXE:  w_state_next = S_SET_WB;
            // Terminal states and the unused codes all return to FETCH.
            default:    w_state_next = S_FETCH;
        endcase
    end

    assign w_done = (r_state == S_MEM_WB) || (r_state == S_MEM_WR) ||
                    (r_state == S_R_WB)   || (r_state == S_BEQ)    ||
                    (r_state == S_BNE)    || (r_state == S_JUMP)   ||
                    (r_state == S_SET_WB);

    // Moore output decode. INIT and the unused codes fall through to all-zero.
    always_comb begin
        ALUOp         = 4'b0000;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNe = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = ALU_LW;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = ALU_LW;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (r_op_q == OP_SW) ? ALU_SW : ALU_LW;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_R_EXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b00;
                ALUOp   = ALU_R;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_BEQ;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_BNE: begin
                ALUSrcA       = 1'b1;
                ALUOp         = ALU_BNE;
                PCWriteCondNe = 1'b1;
                PCSource      = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                ALUOp    = ALU_JMP;
            end
            S_SET_EXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALU_SET;
            end
            S_SET_WB: begin
                RegWrite = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_op_q      <= 6'd0;
            r_instr_cnt <= 16'd0;
            r_err_flag  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_DECODE) begin
                r_op_q <= Opcode;
            end
            // Free-running add of the retire strobe; 16-bit overflow gives the wrap.
            r_instr_cnt <= r_instr_cnt + {15'd0, w_done};
            if (w_illegal) begin
                r_err_flag <= 1'b1;
            end
        end
    end

    assign state      = r_state;
    assign instr_done = w_done;
    assign instr_cnt  = r_instr_cnt;
    assign err_flag   = r_err_flag;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//
// Instruction-level reference model for control_unit. The stimulus process
// knows, for every opcode, the list of states the instruction must visit. It
// queues one expected record per clock cycle. Each record holds the state code,
// the control-signal bundle from the per-state output table, instr_done, the
// retire count and the error flag. The compare process pops one record on every
// falling edge and checks the DUT against it. Directed literal checks pin the
// model at known points.
// ---------------------------------------------------------------------------
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  Opcode = 6'b100011;
    logic [3:0]  ALUOp;
    logic        PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite;
    logic        IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, PCSource;
    logic [3:0]  state;
    logic        instr_done;
    logic [15:0] instr_cnt;
    logic        err_flag;

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .ALUOp(ALUOp),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .state(state),
        .instr_done(instr_done), .instr_cnt(instr_cnt), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [18:0] ctl;
        logic        done;
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_cnt = 16'd0;
    logic        m_err = 1'b0;
    logic [18:0] dut_ctl;

    assign dut_ctl = {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
                      IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    function automatic logic [18:0] mk(input logic pcw, input logic pcc, input logic pcn,
                                       input logic iord, input logic mr, input logic mw,
                                       input logic irw, input logic m2r, input logic rdst,
                                       input logic rw, input logic asa, input logic [1:0] asb,
                                       input logic [1:0] pcs, input logic [3:0] alu);
        return {pcw, pcc, pcn, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, pcs, alu};
    endfunction

    // Per-state control table. Anything not listed for a state is zero.
    function automatic logic [18:0] ctl_of(input int s, input logic [5:0] op);
        case (s)
            0:  return mk(1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,4'h0);
            1:  return mk(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'h0);
            2:  return mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,(op == 6'b101011) ? 4'h1 : 4'h0);
            3:  return mk(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,4'h0);
            4:  return mk(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,4'h0);
            5:  return mk(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,4'h0);
            6:  return mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,4'h4);
            7:  return mk(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,4'h0);
            8:  return mk(0,1,0,0,0,0,0,0,0,0,1,2'b00,2'b01,4'h2);
            9:  return mk(0,0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,4'h3);
            10: return mk(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b10,4'h6);
            11: return mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'h5);
            12: return mk(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,4'h0);
            default: return 19'd0;
        endcase
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000101, 6'b000010, 6'b001010};
    endfunction

    // Queue the expectation for the current cycle, then advance the model.
    task automatic push(input int s, input logic [5:0] op);
        exp_t e;
        e.st   = 4'(s);
        e.ctl  = ctl_of(s, op);
        e.done = (s inside {4, 5, 7, 8, 9, 10, 12});
        e.cnt  = m_cnt;
        e.err  = m_err;
        exp_q.push_back(e);
        if (e.done) m_cnt = m_cnt + 16'd1;
        if (s == 1 && !legal(op)) m_err = 1'b1;
    endtask

    task automatic reset_cycle(input bit rel);
        @(posedge clk); #1;
        if (rel) rst_n = 1'b1;
        push(15, Opcode);
    endtask

    // Run one instruction from FETCH. Optional literal check at chk_st,
    // optional reset abort in MEM_RD, optional counter preload to 0xFFFF.
    task automatic run_instr(input logic [5:0] op, input bit do_chk, input int chk_st,
                             input logic [3:0] chk_alu, input logic [15:0] chk_cnt,
                             input logic chk_err, input bit abort_rd, input bit preload);
        int seq[$];
        seq.push_back(0);
        seq.push_back(1);
        case (op)
            6'b100011: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
            6'b101011: begin seq.push_back(2); seq.push_back(5); end
            6'b000000: begin seq.push_back(6); seq.push_back(7); end
            6'b000100: seq.push_back(8);
            6'b000101: seq.push_back(9);
            6'b000010: seq.push_back(10);
            6'b001010: begin seq.push_back(11); seq.push_back(12); end
            default: ;
        endcase
        foreach (seq[k]) begin
            @(posedge clk); #1;
            if (k == 0) begin
                Opcode = op;
                if (preload) begin
                    force dut.r_instr_cnt = 16'hFFFF;
                    m_cnt = 16'hFFFF;
                end
            end
            if (k == 1 && preload) release dut.r_instr_cnt;
            push(seq[k], op);
            if (do_chk && seq[k] == chk_st) begin
                check("lit_aluop", {28'd0, ALUOp}, {28'd0, chk_alu});
                check("lit_cnt", {16'd0, instr_cnt}, {16'd0, chk_cnt});
                check("lit_err", {31'd0, err_flag}, {31'd0, chk_err});
            end
            if (abort_rd && seq[k] == 3) begin
                @(negedge clk); #1;
                rst_n = 1'b0;
                #1;
                check("rst_state", {28'd0, state}, 32'd15);
                check("rst_ctl", {13'd0, dut_ctl}, 32'd0);
                check("rst_cnt", {16'd0, instr_cnt}, 32'd0);
                check("rst_err", {31'd0, err_flag}, 32'd0);
                m_cnt = 16'd0;
                m_err = 1'b0;
                return;
            end
        end
    endtask

    // Compare process: one expected record per cycle, plus the exclusivity rules.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("state", {28'd0, state}, {28'd0, cur.st});
            check("ctl", {13'd0, dut_ctl}, {13'd0, cur.ctl});
            check("instr_done", {31'd0, instr_done}, {31'd0, cur.done});
            check("instr_cnt", {16'd0, instr_cnt}, {16'd0, cur.cnt});
            check("err_flag", {31'd0, err_flag}, {31'd0, cur.err});
        end
        check("rd_wr_excl", {31'd0, MemRead & MemWrite}, 32'd0);
        check("pc_excl", {31'd0, PCWrite & (PCWriteCond | PCWriteCondNe)}, 32'd0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] legal_ops [7];
        logic [5:0] op;
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                      6'b000101, 6'b000010, 6'b001010};

        // Reset held, then released: INIT shown, then lw from FETCH.
        reset_cycle(0);
        reset_cycle(0);
        reset_cycle(0);
        check("lit_reset_state", {28'd0, state}, 32'd15);
        reset_cycle(1);

        // Directed instructions with literal ALUOp/count/error expectations.
        run_instr(6'b100011, 1, 2,  4'h0, 16'd0, 1'b0, 0, 0);
        run_instr(6'b101011, 1, 2,  4'h1, 16'd1, 1'b0, 0, 0);
        run_instr(6'b000000, 1, 6,  4'h4, 16'd2, 1'b0, 0, 0);
        run_instr(6'b000100, 1, 8,  4'h2, 16'd3, 1'b0, 0, 0);
        run_instr(6'b000101, 1, 9,  4'h3, 16'd4, 1'b0, 0, 0);
        run_instr(6'b000010, 1, 10, 4'h6, 16'd5, 1'b0, 0, 0);
        run_instr(6'b001010, 1, 11, 4'h5, 16'd6, 1'b0, 0, 0);
        run_instr(6'b111111, 1, 1,  4'h0, 16'd7, 1'b0, 0, 0);
        run_instr(6'b000100, 1, 8,  4'h2, 16'd7, 1'b1, 0, 0);

        // Randomized instruction stream, some illegal opcodes mixed in.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 6)];
            else                          op = 6'($urandom);
            run_instr(op, 0, 0, 4'h0, 16'd0, 1'b0, 0, 0);
        end

        // Reset pulse in the middle of a load, then INIT, then FETCH.
        run_instr(6'b100011, 0, 0, 4'h0, 16'd0, 1'b0, 1, 0);
        reset_cycle(0);
        reset_cycle(1);

        // Counter wrap: preload 0xFFFF, beq retires to 0x0000.
        run_instr(6'b000100, 1, 8,  4'h2, 16'hFFFF, 1'b0, 0, 1);
        run_instr(6'b000010, 1, 10, 4'h6, 16'h0000, 1'b0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have no parameters; opcodes, state codes and ALUOp codes are fixed constants.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 Opcode  in  6  IR[31:26]; stable from the DECODE state until the next FETCH.
REQ-005 ALUOp  out  4  to ALU_control.
- Codes: lw 0000, sw 0001, beq 0010, bne 0011, R 0100, set 0101, jmp 0110.
REQ-006 PCWrite, PCWriteCond, PCWriteCondNe  out  1 each  unconditional PC write, PC write gated by Zero, PC write gated by !Zero.
REQ-007 IorD, MemRead, MemWrite, IRWrite  out  1 each  memory address select (1=ALUOut), read strobe, write strobe, IR load.
REQ-008 MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  writeback select (1=MDR), destination select (1=rd), register file write, ALU A select (1=reg A).
REQ-009 ALUSrcB, PCSource  out  2 each  ALU B select (00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2); PC source (00 ALU, 01 ALUOut, 10 jump target).
REQ-010 state  out  4  current state code, for debug.
REQ-011 instr_done  out  1  high while the FSM is in a terminal state.
REQ-012 instr_cnt  out  16  count of retired instructions.
REQ-013 err_flag  out  1  sticky flag for an illegal opcode.

Function
REQ-014 The FSM SHALL use these state codes:
- INIT=15, FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5
- R_EXE=6, R_WB=7, BEQ=8, BNE=9, JUMP=10, SET_EXE=11, SET_WB=12
- Codes 13 and 14 are unused and SHALL go to FETCH on the next edge.
REQ-015 INIT SHALL go to FETCH, and FETCH SHALL go to DECODE.
REQ-016 DECODE SHALL latch Opcode into op_q and branch on it:
- 000000 -> R_EXE, 100011/101011 -> MEM_ADDR, 000100 -> BEQ
- 000101 -> BNE, 000010 -> JUMP, 001010 -> SET_EXE
- any other value -> FETCH, with err_flag set.
REQ-017 MEM_ADDR SHALL branch on op_q: lw -> MEM_RD, sw -> MEM_WR.
REQ-018 Further transitions SHALL be: MEM_RD -> MEM_WB, R_EXE -> R_WB, SET_EXE -> SET_WB.
REQ-019 The terminal states MEM_WB, MEM_WR, R_WB, BEQ, BNE, JUMP and SET_WB SHALL each go to FETCH.
REQ-020 Outputs SHALL be a Moore decode of the current state only; every output not listed for a state is 0.
REQ-021 FETCH: MemRead, IRWrite, PCWrite = 1; ALUSrcB=01; ALUOp=0000.
REQ-022 DECODE: ALUSrcB=11; ALUOp=0000.
REQ-023 MEM_ADDR: ALUSrcA=1; ALUSrcB=10; ALUOp=0000 for lw, 0001 for sw.
REQ-024 MEM_RD: MemRead=1, IorD=1.
REQ-025 MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0.
REQ-026 MEM_WR: MemWrite=1, IorD=1.
REQ-027 R_EXE: ALUSrcA=1; ALUSrcB=00; ALUOp=0100.
REQ-028 R_WB: RegWrite=1, RegDst=1.
REQ-029 BEQ: ALUSrcA=1; ALUOp=0010; PCWriteCond=1; PCSource=01.
REQ-030 BNE: ALUSrcA=1; ALUOp=0011; PCWriteCondNe=1; PCSource=01.
REQ-031 JUMP: PCWrite=1; PCSource=10; ALUOp=0110.
REQ-032 SET_EXE: ALUSrcA=1; ALUSrcB=10; ALUOp=0101.
REQ-033 SET_WB: RegWrite=1, RegDst=0, MemtoReg=0.
REQ-034 INIT and the unused codes SHALL drive every output to 0, ALUOp included.
REQ-035 Instruction latencies from FETCH entry SHALL be: lw 5 cycles; sw, R, set 4; beq, bne, j 3; illegal opcode 2 (no retire).
REQ-036 instr_cnt SHALL increment by 1 on each rising edge while instr_done=1 and wrap from 0xFFFF to 0x0000.
REQ-037 err_flag SHALL be set on the edge leaving DECODE with an illegal opcode and SHALL stay set until reset.
REQ-038 MemWrite and MemRead SHALL never both be 1; PCWrite and PCWriteCond/PCWriteCondNe SHALL never both be 1.

Reset
REQ-039 While rst_n=0, regardless of clk:
- state=INIT, op_q=0, instr_cnt=0, err_flag=0
- all control outputs 0.
REQ-040 Reset asserted mid-instruction SHALL abort it at once, with no count increment; after release the first edge enters INIT -> FETCH.

Verification
REQ-041 Reset release with Opcode=100011 -> states 15,0,1,2,3,4,0; MEM_WB shows RegWrite=1, MemtoReg=1; instr_cnt=1.
REQ-042 sw (101011) -> states 0,1,2,5; MEM_ADDR ALUOp=0001; MEM_WR MemWrite=1, IorD=1; 4 cycles.
REQ-043 Opcodes 000000, 000100, 000101, 000010, 001010 in turn -> ALUOp in the execute state = 0100, 0010, 0011, 0110, 0101; instr_cnt=5.
REQ-044 Opcode=111111 at DECODE -> next state FETCH, err_flag=1 and held, instr_cnt unchanged.
REQ-045 instr_cnt preloaded by running 65535 retires, then one beq -> instr_cnt=0x0000.
REQ-046 rst_n pulsed low during MEM_RD -> outputs 0 within the low phase, instr_cnt=0, then INIT then FETCH.
